// File: rtl/video_pkg.sv
// Shared video constants and receiver state encoding.
package video_pkg;

    localparam int VID_H_ACTIVE = 640;
    localparam int VID_V_ACTIVE = 480;
    localparam int GREY_W       = 8;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } vtr_state_e;

endpackage

// File: rtl/vtr_edge_detect.sv
// Registers DE/VSYNC once and flags the VSYNC falling edge and DE falling edge.
module vtr_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic de_i,
    input  logic vsync_i,
    output logic de_fall_o,
    output logic vs_start_o
);

    logic de_q;
    logic vs_q;

    // vs_q resets low so an idle-high or mid-pulse VSYNC never yields a false start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            de_q <= de_i;
            vs_q <= vsync_i;
        end
    end

    assign de_fall_o  = de_q & ~de_i;
    assign vs_start_o = vs_q & ~vsync_i;

endmodule

// File: rtl/video_timing_receiver.sv
// Sink-side timing checker and single-frame grey capture engine.
// Optional running checksum output FRAME_SUM when VTR_CHECKSUM_EN is defined.
module video_timing_receiver
    import video_pkg::*;
#(
    parameter int H_ACTIVE      = VID_H_ACTIVE,
    parameter int V_ACTIVE      = VID_V_ACTIVE,
    parameter int LOCK_LOSS     = 2,
    parameter int FRAME_TIMEOUT = 500000,
    parameter int ADDR_W        = 19
) (
    input  logic              CLK_PX,
    input  logic              RST,
    input  logic              DE,
    input  logic              HSYNC,
    input  logic              VSYNC,
    input  logic [23:0]       PX,
    input  logic              CAPTURE_REQ,
    output logic              CAPTURE_BUSY,
    output logic              FRAME_DONE,
    output logic              CAPTURE_ERR,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA,
    output logic [9:0]        PX_X,
    output logic [9:0]        PX_Y,
    output logic              LOCKED,
    output logic              ERR_LINE,
    output logic              ERR_FRAME
`ifdef VTR_CHECKSUM_EN
    ,
    output logic [23:0]       FRAME_SUM
`endif
);

    localparam int TMO_W = $clog2(FRAME_TIMEOUT + 1);
    localparam int BAD_W = $clog2(LOCK_LOSS + 1);
    localparam logic [10:0]      H_ACT_C = 11'(H_ACTIVE);
    localparam logic [9:0]       V_ACT_C = 10'(V_ACTIVE);
    localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(FRAME_TIMEOUT);
    localparam logic [BAD_W-1:0] LOSS_C  = BAD_W'(LOCK_LOSS);

    logic vs_start;
    logic de_fall;

    vtr_edge_detect u_edge (
        .clk_i      (CLK_PX),
        .rst_i      (RST),
        .de_i       (DE),
        .vsync_i    (VSYNC),
        .de_fall_o  (de_fall),
        .vs_start_o (vs_start)
    );

    // HSYNC carries no timing information here; upper colour bits are not captured
    logic unused_inputs;
    assign unused_inputs = ^{HSYNC, PX[23:GREY_W]};

    vtr_state_e         state_q, state_d;
    logic [10:0]        cnt_x_q, cnt_x_d;
    logic [9:0]         cnt_y_q, cnt_y_d;
    logic               line_bad_q, line_bad_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               pend_q, pend_d;
    logic               armed_q, armed_d;
    logic [ADDR_W-1:0]  wa_q, wa_d;
    logic               locked_q, locked_d;
    logic               err_line_q, err_line_d;
    logic               err_frame_q, err_frame_d;
    logic               done_q, done_d;
    logic               cerr_q, cerr_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [GREY_W-1:0]  wr_data_q, wr_data_d;
    logic [9:0]         px_x_q, px_x_d;
    logic [9:0]         px_y_q, px_y_d;
`ifdef VTR_CHECKSUM_EN
    logic [23:0]        sum_q, sum_d;
`endif

    logic             line_mis;
    logic             frame_good;
    logic             tmo_hit;
    logic             stay_locked;
    logic [BAD_W-1:0] bad_inc;

    always_comb begin
        state_d     = state_q;
        cnt_x_d     = cnt_x_q;
        cnt_y_d     = cnt_y_q;
        line_bad_d  = line_bad_q;
        bad_d       = bad_q;
        tmo_d       = tmo_q;
        pend_d      = pend_q;
        armed_d     = armed_q;
        wa_d        = wa_q;
        err_line_d  = 1'b0;
        err_frame_d = 1'b0;
        done_d      = 1'b0;
        cerr_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        px_x_d      = px_x_q;
        px_y_d      = px_y_q;
`ifdef VTR_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        line_mis   = de_fall && (cnt_x_q != H_ACT_C);
        frame_good = (cnt_y_q == V_ACT_C) && !line_bad_q;
        tmo_hit    = (tmo_q == TMO_C);
        bad_inc    = bad_q + BAD_W'(1);

        if (de_fall)
            cnt_x_d = '0;
        else if (DE && cnt_x_q != '1)
            cnt_x_d = cnt_x_q + 11'd1;

        if (vs_start)
            cnt_y_d = '0;
        else if (de_fall && cnt_y_q != '1)
            cnt_y_d = cnt_y_q + 10'd1;

        if (vs_start)
            line_bad_d = 1'b0;
        else if (line_mis)
            line_bad_d = 1'b1;

        if (vs_start)
            tmo_d = '0;
        else if (!tmo_hit)
            tmo_d = tmo_q + TMO_W'(1);

        case (state_q)
            ST_SEARCH: if (vs_start) state_d = ST_ALIGN;
            ST_ALIGN:  if (vs_start && frame_good) state_d = ST_LOCKED;
            ST_LOCKED: begin
                if (vs_start) begin
                    if (frame_good)
                        bad_d = '0;
                    else if (bad_inc >= LOSS_C)
                        state_d = ST_SEARCH;
                    else
                        bad_d = bad_inc;
                end
            end
            default:   state_d = ST_SEARCH;
        endcase

        if (tmo_hit && state_q != ST_SEARCH)
            state_d = ST_SEARCH;
        if (state_d != ST_LOCKED)
            bad_d = '0;

        locked_d    = (state_d == ST_LOCKED);
        err_line_d  = (state_q == ST_LOCKED) && line_mis;
        err_frame_d = (state_q == ST_LOCKED) && vs_start && (cnt_y_q != V_ACT_C);
        stay_locked = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);

        // Abort wins over completion and over any write in the same cycle
        if (armed_q) begin
            if (!stay_locked) begin
                armed_d = 1'b0;
                cerr_d  = 1'b1;
            end else if (vs_start) begin
                armed_d = 1'b0;
                done_d  = 1'b1;
            end else if (DE && cnt_x_q < H_ACT_C && cnt_y_q < V_ACT_C) begin
                wr_en_d   = 1'b1;
                wr_addr_d = wa_q;
                wa_d      = wa_q + ADDR_W'(1);
                wr_data_d = PX[GREY_W-1:0];
                px_x_d    = cnt_x_q[9:0];
                px_y_d    = cnt_y_q;
`ifdef VTR_CHECKSUM_EN
                sum_d     = sum_q + 24'(PX[GREY_W-1:0]);
`endif
            end
        end else if (pend_q && vs_start && stay_locked) begin
            armed_d = 1'b1;
            pend_d  = 1'b0;
            wa_d    = '0;
`ifdef VTR_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else if (CAPTURE_REQ && !pend_q) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_PX) begin
        if (RST) begin
            state_q     <= ST_SEARCH;
            cnt_x_q     <= '0;
            cnt_y_q     <= '0;
            line_bad_q  <= 1'b0;
            bad_q       <= '0;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
            armed_q     <= 1'b0;
            wa_q        <= '0;
            locked_q    <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
            done_q      <= 1'b0;
            cerr_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            px_x_q      <= '0;
            px_y_q      <= '0;
`ifdef VTR_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_x_q     <= cnt_x_d;
            cnt_y_q     <= cnt_y_d;
            line_bad_q  <= line_bad_d;
            bad_q       <= bad_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            armed_q     <= armed_d;
            wa_q        <= wa_d;
            locked_q    <= locked_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
            done_q      <= done_d;
            cerr_q      <= cerr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            px_x_q      <= px_x_d;
            px_y_q      <= px_y_d;
`ifdef VTR_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign CAPTURE_BUSY = pend_q | armed_q;
    assign FRAME_DONE   = done_q;
    assign CAPTURE_ERR  = cerr_q;
    assign WR_EN        = wr_en_q;
    assign WR_ADDR      = wr_addr_q;
    assign WR_DATA      = wr_data_q;
    assign PX_X         = px_x_q;
    assign PX_Y         = px_y_q;
    assign LOCKED       = locked_q;
    assign ERR_LINE     = err_line_q;
    assign ERR_FRAME    = err_frame_q;
`ifdef VTR_CHECKSUM_EN
    assign FRAME_SUM    = sum_q;
`endif

endmodule

// File: tb/tb_video_timing_receiver.sv
// Directed bench for video_timing_receiver on a 16x8 active geometry with a write scoreboard.
module tb_video_timing_receiver;

    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              RST, DE, HSYNC, VSYNC, CAPTURE_REQ;
    logic [23:0]       PX;
    logic              CAPTURE_BUSY, FRAME_DONE, CAPTURE_ERR, WR_EN, LOCKED, ERR_LINE, ERR_FRAME;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [7:0]        WR_DATA;
    logic [9:0]        PX_X, PX_Y;
`ifdef VTR_CHECKSUM_EN
    logic [23:0]       FRAME_SUM;
`endif

    video_timing_receiver #(
        .H_ACTIVE(16), .V_ACTIVE(8), .LOCK_LOSS(2), .FRAME_TIMEOUT(1000), .ADDR_W(ADDR_W)
    ) dut (
        .CLK_PX(clk), .RST(RST), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC), .PX(PX),
        .CAPTURE_REQ(CAPTURE_REQ), .CAPTURE_BUSY(CAPTURE_BUSY), .FRAME_DONE(FRAME_DONE),
        .CAPTURE_ERR(CAPTURE_ERR), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .PX_X(PX_X), .PX_Y(PX_Y), .LOCKED(LOCKED), .ERR_LINE(ERR_LINE), .ERR_FRAME(ERR_FRAME)
`ifdef VTR_CHECKSUM_EN
        , .FRAME_SUM(FRAME_SUM)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_eline  = 0;
    int n_eframe = 0;
    int n_done   = 0;
    int n_cerr   = 0;
    int n_wr     = 0;
    int waddr    = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event counters and write scoreboard, sampled away from the active edge
    always @(negedge clk) begin
        if (ERR_LINE)    n_eline++;
        if (ERR_FRAME)   n_eframe++;
        if (FRAME_DONE)  n_done++;
        if (CAPTURE_ERR) n_cerr++;
        if (WR_EN) begin
            n_wr++;
            if (sb_q.size() == 0) begin
                check("wr_unexpected", 64'(WR_EN), 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("wr_word", 64'({WR_ADDR, WR_DATA, PX_X, PX_Y}), e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int npx, input int y, input bit push);
        for (int i = 0; i < 4; i++) begin
            DE = 1'b0;
            HSYNC = (i < 2) ? 1'b0 : 1'b1;
            tick();
        end
        for (int x = 0; x < npx; x++) begin
            DE = 1'b1;
            PX = {16'hA5C3, 8'(x + 16 * y)};
            if (push && x < 16 && y < 8) begin
                sb_q.push_back(64'({19'(waddr), 8'(x + 16 * y), 10'(x), 10'(y)}));
                waddr++;
            end
            tick();
        end
        DE = 1'b0;
    endtask

    task automatic lines(input int n, input int short_idx, input bit push);
        for (int y = 0; y < n; y++)
            line((y == short_idx) ? 15 : 16, y, push);
        DE = 1'b0;
        tick();
        tick();
    endtask

    task automatic vsync_pulse();
        DE = 1'b0;
        VSYNC = 1'b0;
        tick();
        tick();
        VSYNC = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic req_pulse();
        CAPTURE_REQ = 1'b1;
        tick();
        CAPTURE_REQ = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({CAPTURE_BUSY, FRAME_DONE, CAPTURE_ERR, WR_EN, WR_ADDR, WR_DATA,
                    PX_X, PX_Y, LOCKED, ERR_LINE, ERR_FRAME});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; DE = 1'b0; HSYNC = 1'b1; VSYNC = 1'b1; PX = '0; CAPTURE_REQ = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        tick();
        RST = 1'b0;

        // Acquire lock: garbage, then two vsync edges
        lines(3, -1, 0);
        vsync_pulse();
        @(negedge clk); check("align_not_locked", 64'(LOCKED), 64'd0);
        lines(8, -1, 0);
        vsync_pulse();
        @(negedge clk); check("locked_after_2nd_vs", 64'(LOCKED), 64'd1);
        check("no_err_during_lock", 64'(n_eline + n_eframe), 64'd0);

        // Short line while locked
        lines(8, 3, 0);
        vsync_pulse();
        @(negedge clk);
        check("short_line_err_line", 64'(n_eline), 64'd1);
        check("short_line_err_frame", 64'(n_eframe), 64'd0);
        check("short_line_still_locked", 64'(LOCKED), 64'd1);
        lines(8, -1, 0);
        vsync_pulse();

        // Full capture
        req_pulse();
        @(negedge clk); check("busy_after_req", 64'(CAPTURE_BUSY), 64'd1);
        tick();
        req_pulse();
        lines(8, -1, 0);
        vsync_pulse();
        waddr = 0;
        lines(8, -1, 1);
        @(negedge clk); check("no_done_before_close", 64'(n_done), 64'd0);
        vsync_pulse();
        @(negedge clk);
        check("capture_done", 64'(n_done), 64'd1);
        check("capture_writes", 64'(n_wr), 64'd128);
        check("capture_sb_empty", 64'(sb_q.size()), 64'd0);
        check("capture_busy_clear", 64'(CAPTURE_BUSY), 64'd0);
        check("capture_no_err", 64'(n_cerr), 64'd0);
`ifdef VTR_CHECKSUM_EN
        check("frame_sum", 64'(FRAME_SUM), 64'd8128);
`endif

        // Capture aborted by frame timeout
        req_pulse();
        lines(8, -1, 0);
        vsync_pulse();
        waddr = 0;
        lines(3, -1, 1);
        VSYNC = 1'b1; DE = 1'b0;
        for (int i = 0; i < 1100; i++) tick();
        @(negedge clk);
        check("timeout_capture_err", 64'(n_cerr), 64'd1);
        check("timeout_unlocked", 64'(LOCKED), 64'd0);
        check("timeout_busy_clear", 64'(CAPTURE_BUSY), 64'd0);
        check("timeout_writes", 64'(n_wr), 64'd176);
        check("timeout_no_done", 64'(n_done), 64'd1);
        lines(2, -1, 0);
        @(negedge clk); check("no_writes_after_abort", 64'(n_wr), 64'd176);

        // Relock, then two short frames
        vsync_pulse();
        lines(8, -1, 0);
        vsync_pulse();
        @(negedge clk); check("relock_after_timeout", 64'(LOCKED), 64'd1);
        lines(7, -1, 0);
        vsync_pulse();
        @(negedge clk);
        check("short_frame1_err", 64'(n_eframe), 64'd1);
        check("short_frame1_locked", 64'(LOCKED), 64'd1);
        lines(7, -1, 0);
        vsync_pulse();
        @(negedge clk);
        check("short_frame2_err", 64'(n_eframe), 64'd2);
        check("short_frame2_unlocked", 64'(LOCKED), 64'd0);
        check("short_frames_no_line_err", 64'(n_eline), 64'd1);

        // Relock, arm a capture, reset mid-frame
        lines(8, -1, 0);
        vsync_pulse();
        lines(8, -1, 0);
        vsync_pulse();
        @(negedge clk); check("relock_before_reset", 64'(LOCKED), 64'd1);
        req_pulse();
        lines(8, -1, 0);
        vsync_pulse();
        waddr = 0;
        lines(2, -1, 1);
        RST = 1'b1;
        tick();
        @(negedge clk); check("midframe_reset_outputs", all_outs(), 64'd0);
        tick();
        RST = 1'b0;
        lines(3, -1, 0);
        vsync_pulse();
        @(negedge clk); check("post_reset_first_vs", 64'(LOCKED), 64'd0);
        lines(8, -1, 0);
        vsync_pulse();
        @(negedge clk);
        check("post_reset_relock", 64'(LOCKED), 64'd1);
        check("reset_no_done", 64'(n_done), 64'd1);
        check("reset_no_capture_err", 64'(n_cerr), 64'd1);
        check("reset_busy_clear", 64'(CAPTURE_BUSY), 64'd0);
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
